// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Screen geometry, play-band limits, obstacle-slot field widths
//                and game-mode encoding shared by the obstacle generator and
//                the game logic.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package game_pkg;

    // Screen and play-band geometry (pixels)
    localparam int SCREEN_W    = 640;
    localparam int UPPER_BOUND = 20;
    localparam int LOWER_BOUND = 460;
    localparam int OBS_WIDTH   = 40;

    // Slot array shape and packed field widths
    localparam int N_SLOTS  = 10;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int X_PAIR_W = 2 * X_W;   // {x_left, x_right}
    localparam int Y_PAIR_W = 2 * Y_W;   // {y_top, y_bottom}

    typedef enum logic [1:0] {
        GM_INIT  = 2'b00,
        GM_PLAY  = 2'b01,
        GM_PAUSE = 2'b10,
        GM_END   = 2'b11
    } gamemode_t;

endpackage
`default_nettype wire

// File: rtl/obstacle_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : obstacle_gen_if
//  Description : Game-mode/frame-tick inputs and packed obstacle outputs of
//                the obstacle generator.
//  Signals     : tick        - one-cycle frame enable
//                gamemode    - 00 init, 01 play, 10 pause, 11 ended
//                obstacle_x  - slot i at [20i+19:20i] = {x_left, x_right}
//                obstacle_y  - slot i at [18i+17:18i] = {y_top, y_bottom}
//                active      - bit i set when slot i is live
//                spawn_drop  - pulse when a due spawn found no free slot
//  Modports    : master (tick/mode source), slave (obstacle generator)
//  Revision    : 1.0  initial release
// ============================================================================
interface obstacle_gen_if;

    logic                                                tick;
    logic [1:0]                                          gamemode;
    logic [game_pkg::N_SLOTS*game_pkg::X_PAIR_W-1:0]     obstacle_x;
    logic [game_pkg::N_SLOTS*game_pkg::Y_PAIR_W-1:0]     obstacle_y;
    logic [game_pkg::N_SLOTS-1:0]                        active;
    logic                                                spawn_drop;

    modport master (
        output tick,
        output gamemode,
        input  obstacle_x,
        input  obstacle_y,
        input  active,
        input  spawn_drop
    );

    modport slave (
        input  tick,
        input  gamemode,
        output obstacle_x,
        output obstacle_y,
        output active,
        output spawn_drop
    );

endinterface
`default_nettype wire

// File: rtl/obstacle_gen_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : 16-bit Fibonacci LFSR, taps 16/14/13/11, shifting left with
//                the feedback bit entering at bit 0. Advances only when en=1.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset (loads SEED)
//                en   - advance enable
//                q    - current LFSR state
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic        w_fb;

    // Tap n (1-based) is bit n-1
    assign w_fb = q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= SEED;
        end else if (en) begin
            q_q <= {q_q[14:0], w_fb};
        end
    end

    assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/obstacle_gen.sv
`default_nettype none
// ============================================================================
//  Module      : obstacle_gen
//  Description : Ten-slot obstacle generator. Spawns obstacles at the right
//                screen edge every SPAWN_INTERVAL in-game ticks, takes height
//                and top/bottom placement from an LFSR, scrolls live slots
//                left each tick and retires them once they leave the screen.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                bus  - obstacle_gen_if.slave (tick/gamemode in, packed
//                       obstacle buses, active mask and spawn_drop out)
//  Revision    : 1.0  initial release
// ============================================================================
module obstacle_gen
    import game_pkg::*;
#(
    parameter int          SCROLL_SPEED   = 4,
    parameter int          SPAWN_INTERVAL = 48,
    parameter int          MIN_H          = 80,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    obstacle_gen_if.slave bus
);

    localparam int             CNT_W    = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
    localparam int             IDX_W    = $clog2(N_SLOTS);
    localparam logic [X_W-1:0] SPAWN_XL = X_W'(SCREEN_W);
    localparam logic [X_W-1:0] SPAWN_XR = X_W'(SCREEN_W + OBS_WIDTH);
    localparam logic [X_W-1:0] STEP     = X_W'(SCROLL_SPEED);
    localparam logic [Y_W-1:0] Y_UPPER  = Y_W'(UPPER_BOUND);
    localparam logic [Y_W-1:0] Y_LOWER  = Y_W'(LOWER_BOUND);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_INTERVAL - 1);

    // ------------------------------------------------------------------
    // Slot register file
    // ------------------------------------------------------------------
    logic [X_W-1:0]     xl_q [N_SLOTS];
    logic [X_W-1:0]     xl_d [N_SLOTS];
    logic [X_W-1:0]     xr_q [N_SLOTS];
    logic [X_W-1:0]     xr_d [N_SLOTS];
    logic [Y_W-1:0]     yt_q [N_SLOTS];
    logic [Y_W-1:0]     yt_d [N_SLOTS];
    logic [Y_W-1:0]     yb_q [N_SLOTS];
    logic [Y_W-1:0]     yb_d [N_SLOTS];
    logic [N_SLOTS-1:0] act_q;
    logic [N_SLOTS-1:0] act_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               drop_q;
    logic               drop_d;

    gamemode_t          w_mode;
    logic               w_play_tick;
    logic               w_due;
    logic [15:0]        w_lfsr;
    logic               w_unused_lfsr;
    logic [Y_W-1:0]     w_h;
    logic [Y_W-1:0]     w_new_top;
    logic [Y_W-1:0]     w_new_bot;
    logic               w_free_found;
    logic [IDX_W-1:0]   w_free_idx;

    assign w_mode      = gamemode_t'(bus.gamemode);
    assign w_play_tick = (w_mode == GM_PLAY) && bus.tick;
    assign w_due       = (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // Random geometry source
    // ------------------------------------------------------------------
    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (w_play_tick),
        .q   (w_lfsr)
    );

    // Only the low byte shapes the obstacle
    assign w_unused_lfsr = ^w_lfsr[15:8];

    assign w_h       = Y_W'(MIN_H) + Y_W'(w_lfsr[7:1]);
    assign w_new_top = w_lfsr[0] ? (Y_LOWER - w_h) : Y_UPPER;
    assign w_new_bot = w_lfsr[0] ? Y_LOWER : (Y_UPPER + w_h);

    // ------------------------------------------------------------------
    // Lowest-index free slot, judged on pre-tick occupancy so a slot that
    // retires this tick is not reused until the next spawn.
    // ------------------------------------------------------------------
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!act_q[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state: mode clear, then scroll/retire and spawn on a play tick
    // ------------------------------------------------------------------
    always_comb begin
        xl_d   = xl_q;
        xr_d   = xr_q;
        yt_d   = yt_q;
        yb_d   = yb_q;
        act_d  = act_q;
        cnt_d  = cnt_q;
        drop_d = 1'b0;

        if (w_mode == GM_INIT) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                xl_d[i] = '0;
                xr_d[i] = '0;
                yt_d[i] = '0;
                yb_d[i] = '0;
            end
            act_d = '0;
            cnt_d = '0;
        end else if (w_play_tick) begin
            cnt_d = w_due ? '0 : cnt_q + 1'b1;

            for (int i = 0; i < N_SLOTS; i++) begin
                if (act_q[i]) begin
                    if (xr_q[i] <= STEP) begin
                        xl_d[i]  = '0;
                        xr_d[i]  = '0;
                        yt_d[i]  = '0;
                        yb_d[i]  = '0;
                        act_d[i] = 1'b0;
                    end else begin
                        xr_d[i] = xr_q[i] - STEP;
                        xl_d[i] = (xl_q[i] > STEP) ? (xl_q[i] - STEP) : '0;
                    end
                end
            end

            // The target slot was inactive, so the scroll loop never touched it
            if (w_due) begin
                if (w_free_found) begin
                    xl_d[w_free_idx]  = SPAWN_XL;
                    xr_d[w_free_idx]  = SPAWN_XR;
                    yt_d[w_free_idx]  = w_new_top;
                    yb_d[w_free_idx]  = w_new_bot;
                    act_d[w_free_idx] = 1'b1;
                end else begin
                    drop_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                xl_q[i] <= '0;
                xr_q[i] <= '0;
                yt_q[i] <= '0;
                yb_q[i] <= '0;
            end
            act_q  <= '0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            xl_q   <= xl_d;
            xr_q   <= xr_d;
            yt_q   <= yt_d;
            yb_q   <= yb_d;
            act_q  <= act_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Packed output buses
    // ------------------------------------------------------------------
    logic [N_SLOTS*X_PAIR_W-1:0] w_obs_x;
    logic [N_SLOTS*Y_PAIR_W-1:0] w_obs_y;

    always_comb begin
        w_obs_x = '0;
        w_obs_y = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_obs_x[i*X_PAIR_W +: X_PAIR_W] = {xl_q[i], xr_q[i]};
            w_obs_y[i*Y_PAIR_W +: Y_PAIR_W] = {yt_q[i], yb_q[i]};
        end
    end

    assign bus.obstacle_x = w_obs_x;
    assign bus.obstacle_y = w_obs_y;
    assign bus.active     = act_q;
    assign bus.spawn_drop = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_obstacle_gen
//  Description : Testbench for obstacle_gen. Two instances (spawn interval 1
//                and 1000) share reset/mode/tick stimulus; a slot-level
//                behavioural model predicts every output each cycle, and
//                literal expectations pin key points of the sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_obstacle_gen;

    localparam int NS = 10;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    obstacle_gen_if if_a ();
    obstacle_gen_if if_b ();

    obstacle_gen #(.SPAWN_INTERVAL(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    obstacle_gen #(.SPAWN_INTERVAL(1000)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    int m_xl [2][NS];
    int m_xr [2][NS];
    int m_yt [2][NS];
    int m_yb [2][NS];
    bit m_act [2][NS];
    int m_cnt [2];
    int m_l [2];
    bit m_drop [2];

    function automatic int interval(input int k);
        return (k == 0) ? 1 : 1000;
    endfunction

    task automatic clear_slots(input int k);
        for (int i = 0; i < NS; i++) begin
            m_xl[k][i] = 0; m_xr[k][i] = 0; m_yt[k][i] = 0; m_yb[k][i] = 0;
            m_act[k][i] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input bit r, input int gm, input bit t);
        int  fidx;
        bit  due;
        int  h;
        int  fb;
        if (r) begin
            clear_slots(k);
            m_cnt[k] = 0; m_l[k] = 16'hACE1; m_drop[k] = 1'b0;
        end else if (gm == 0) begin
            clear_slots(k);
            m_cnt[k] = 0; m_drop[k] = 1'b0;
        end else if (gm == 1 && t) begin
            due = (m_cnt[k] == interval(k) - 1);
            m_cnt[k] = due ? 0 : m_cnt[k] + 1;
            fidx = -1;
            for (int i = NS - 1; i >= 0; i--) if (!m_act[k][i]) fidx = i;
            for (int i = 0; i < NS; i++) begin
                if (m_act[k][i]) begin
                    if (m_xr[k][i] <= 4) begin
                        m_xl[k][i] = 0; m_xr[k][i] = 0; m_yt[k][i] = 0; m_yb[k][i] = 0;
                        m_act[k][i] = 1'b0;
                    end else begin
                        m_xr[k][i] = m_xr[k][i] - 4;
                        m_xl[k][i] = (m_xl[k][i] > 4) ? m_xl[k][i] - 4 : 0;
                    end
                end
            end
            m_drop[k] = 1'b0;
            if (due) begin
                if (fidx >= 0) begin
                    h = 80 + ((m_l[k] >> 1) & 127);
                    m_xl[k][fidx] = 640;
                    m_xr[k][fidx] = 680;
                    if (m_l[k] & 1) begin
                        m_yt[k][fidx] = 460 - h; m_yb[k][fidx] = 460;
                    end else begin
                        m_yt[k][fidx] = 20; m_yb[k][fidx] = 20 + h;
                    end
                    m_act[k][fidx] = 1'b1;
                end else begin
                    m_drop[k] = 1'b1;
                end
            end
            fb = ((m_l[k] >> 15) ^ (m_l[k] >> 13) ^ (m_l[k] >> 12) ^ (m_l[k] >> 10)) & 1;
            m_l[k] = ((m_l[k] << 1) | fb) & 16'hFFFF;
        end else begin
            m_drop[k] = 1'b0;
        end
    endtask

    function automatic logic [199:0] exp_x(input int k);
        logic [199:0] v = '0;
        for (int i = 0; i < NS; i++) v[20*i +: 20] = {10'(m_xl[k][i]), 10'(m_xr[k][i])};
        return v;
    endfunction

    function automatic logic [199:0] exp_y(input int k);
        logic [199:0] v = '0;
        for (int i = 0; i < NS; i++) v[18*i +: 18] = {9'(m_yt[k][i]), 9'(m_yb[k][i])};
        return v;
    endfunction

    function automatic logic [199:0] exp_act(input int k);
        logic [199:0] v = '0;
        for (int i = 0; i < NS; i++) v[i] = m_act[k][i];
        return v;
    endfunction

    task automatic check(input string name, input logic [199:0] got, input logic [199:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("a_obstacle_x", if_a.obstacle_x, exp_x(0));
            check("a_obstacle_y", if_a.obstacle_y, exp_y(0));
            check("a_active",     if_a.active,     exp_act(0));
            check("a_spawn_drop", if_a.spawn_drop, 200'(m_drop[0]));
            check("b_obstacle_x", if_b.obstacle_x, exp_x(1));
            check("b_obstacle_y", if_b.obstacle_y, exp_y(1));
            check("b_active",     if_b.active,     exp_act(1));
            check("b_spawn_drop", if_b.spawn_drop, 200'(m_drop[1]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit r, input int gm, input bit t);
        rst           = r;
        if_a.gamemode = 2'(gm);
        if_b.gamemode = 2'(gm);
        if_a.tick     = t;
        if_b.tick     = t;
        @(posedge clk);
        #1;
        model_step(0, r, gm, t);
        model_step(1, r, gm, t);
    endtask

    initial begin
        rst = 1'b1;
        if_a.gamemode = 2'b00; if_b.gamemode = 2'b00;
        if_a.tick = 1'b0;      if_b.tick = 1'b0;

        // Reset
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk_en = 1'b1;
        check("rst_active_a", if_a.active, 200'd0);
        check("rst_x_b", if_b.obstacle_x, 200'd0);

        // First spawn on dut_a
        cyc(0, 1, 1);
        check("first_x", if_a.obstacle_x[19:0], 200'({10'd640, 10'd680}));
        check("first_y", if_a.obstacle_y[17:0], 200'({9'd268, 9'd460}));
        check("first_active", if_a.active, 200'd1);

        // Fill all ten slots
        for (int i = 0; i < 9; i++) cyc(0, 1, 1);
        check("full_active", if_a.active, 200'h3FF);
        check("full_no_drop", if_a.spawn_drop, 200'd0);
        cyc(0, 1, 1);
        check("drop_pulse", if_a.spawn_drop, 200'd1);
        check("drop_slot0_x", if_a.obstacle_x[19:0], 200'({10'd600, 10'd640}));
        check("drop_slot9_x", if_a.obstacle_x[199:180], 200'({10'd636, 10'd676}));
        cyc(0, 1, 0);
        check("drop_once", if_a.spawn_drop, 200'd0);

        // Pause and ended modes freeze everything despite ticks
        for (int i = 0; i < 20; i++) cyc(0, 2, 1);
        cyc(0, 3, 1);
        check("pause_hold_x", if_a.obstacle_x[19:0], 200'({10'd600, 10'd640}));
        check("pause_hold_act", if_a.active, 200'h3FF);

        // Bring dut_b to its 1000th in-game tick (11 done so far)
        for (int i = 0; i < 988; i++) cyc(0, 1, 1);
        check("b_pre_spawn", if_b.active, 200'd0);
        cyc(0, 1, 1);
        check("b_spawn_x", if_b.obstacle_x[19:0], 200'({10'd640, 10'd680}));
        check("b_spawn_act", if_b.active, 200'd1);
        cyc(0, 1, 1);
        check("b_scroll1", if_b.obstacle_x[19:0], 200'({10'd636, 10'd676}));
        for (int i = 0; i < 168; i++) cyc(0, 1, 1);
        check("b_edge", if_b.obstacle_x[19:0], 200'({10'd0, 10'd4}));
        cyc(0, 1, 1);
        check("b_retired_act", if_b.active, 200'd0);
        check("b_retired_x", if_b.obstacle_x, 200'd0);

        // Mode clear without a tick
        cyc(0, 0, 0);
        check("clear_act", if_a.active, 200'd0);
        check("clear_x", if_a.obstacle_x, 200'd0);

        // Reset mid-operation, then confirm the LFSR restarted at its seed
        for (int i = 0; i < 5; i++) cyc(0, 1, 1);
        cyc(1, 1, 1);
        check("midrst_act", if_a.active, 200'd0);
        check("midrst_y", if_a.obstacle_y, 200'd0);
        cyc(0, 1, 1);
        check("seed_y", if_a.obstacle_y[17:0], 200'({9'd268, 9'd460}));
        check("seed_x", if_a.obstacle_x[19:0], 200'({10'd640, 10'd680}));

        cyc(0, 1, 0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/obstacle_gen.md
# obstacle_gen

Produces the packed obstacle buses that the player/game-state logic consumes for drawing and collision. It holds up to 10 obstacle slots, spawns new obstacles at the right screen edge on a fixed tick interval, and takes each obstacle's height and top/bottom placement from an LFSR. It scrolls the obstacles left once per frame tick and retires them when they leave the screen. It sits between the game-mode/frame-tick source and the game logic and VGA renderer.

## Interface
- `SCREEN_W`, 640: spawn x coordinate (left edge) and screen width.
- `UPPER_BOUND`, 20: top of the play band (y).
- `LOWER_BOUND`, 460: bottom of the play band (y).
- `OBS_WIDTH`, 40: obstacle width in pixels.
- `SCROLL_SPEED`, 4: pixels moved left per tick.
- `SPAWN_INTERVAL`, 48: ticks between spawn attempts (≥1).
- `MIN_H`, 80: minimum obstacle height.
- `LFSR_SEED`, 16'hACE1: LFSR value after reset (nonzero).
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `tick`  in  1: one-cycle frame enable; all game-state updates occur only on `tick`.
- `gamemode`  in  2: 00 = initial, 01 = in-game, 10 = paused, 11 = ended.
- `obstacle_x`  out  200: slot i at [20i+19:20i] = {x_left[9:0], x_right[9:0]}.
- `obstacle_y`  out  180: slot i at [18i+17:18i] = {y_top[8:0], y_bottom[8:0]}.
- `active`  out  10: bit i is 1 when slot i holds a live obstacle.
- `spawn_drop`  out  1: one-cycle pulse when a spawn is due but all 10 slots are active.

## Operation
- Inactive slot: its x and y fields read all-zero.
- `rst`:
  - all slots inactive and zero; `active` = 0; `spawn_drop` = 0.
  - spawn counter = 0; LFSR = `LFSR_SEED`.
- `gamemode` 00, any cycle (no tick needed): clear all slots and the spawn counter; the LFSR holds its value.
- `gamemode` 10 or 11: everything freezes, including the LFSR and the spawn counter.
- `gamemode` 01 with `tick`: all three steps below are evaluated from pre-tick state.
  - **Scroll.** For each active slot:
    - if x_right ≤ `SCROLL_SPEED`, the slot is freed (zeroed, active cleared);
    - else x_right -= `SCROLL_SPEED`, and x_left = x_left > `SCROLL_SPEED` ? x_left − `SCROLL_SPEED` : 0 (saturating).
  - **Spawn counter.** Counts 0..`SPAWN_INTERVAL`−1. A spawn is due when the counter equals `SPAWN_INTERVAL`−1; the counter then wraps to 0.
  - **Spawn.** When a spawn is due:
    - target is the lowest-index slot inactive before this tick;
    - a slot freed on this same tick is not reused until the next spawn;
    - if no slot is free, pulse `spawn_drop` and do not spawn;
    - the new slot gets x_left = `SCREEN_W`, x_right = `SCREEN_W` + `OBS_WIDTH`;
    - it is not scrolled on its spawn tick.
  - **Geometry**, using the pre-advance LFSR value L:
    - h = `MIN_H` + L[7:1];
    - L[0] = 0: top obstacle, y_top = `UPPER_BOUND`, y_bottom = `UPPER_BOUND` + h;
    - L[0] = 1: bottom obstacle, y_top = `LOWER_BOUND` − h, y_bottom = `LOWER_BOUND`.
  - **LFSR.** Advances once per tick in gamemode 01, whether or not a spawn occurs.
    - Fibonacci form, taps 16, 14, 13, 11; shifts left; feedback enters at bit 0.
- Width rules:
  - x arithmetic is 10-bit; `SCREEN_W` + `OBS_WIDTH` ≤ 1023.
  - y arithmetic is 9-bit; `MIN_H` + 127 ≤ `LOWER_BOUND` − `UPPER_BOUND`.

## Timing
- All outputs are registered and reflect a tick one cycle after the `tick` cycle.
- `spawn_drop` is high for exactly the one cycle that follows the dropping tick.
- `rst` has priority over `gamemode`; `gamemode` 00 has priority over `tick`.
- A `gamemode` change mid-game takes effect on the same edge; no partial slot updates occur.
- `tick` in gamemode 00, 10 or 11 has no effect apart from the gamemode-00 clear.

## Structure
- A shared package `game_pkg` holds the screen and play-band constants (`SCREEN_W`, `UPPER_BOUND`, `LOWER_BOUND`, `OBS_WIDTH`) and the slot field widths. The game logic uses the same package.
- Sub-module `lfsr16`: ports clk, rst, en, seed parameter, q[15:0].
- The slot array is a per-slot register file with a priority encoder for free-slot selection.

## Test plan
- **First spawn.** `SPAWN_INTERVAL`=1, reset, gamemode 01, one tick.
  - Slot 0 active with x = {640, 680}.
  - L = ACE1 gives L[0]=1, h = 80+112 = 192, so y = {268, 460}.
- **Scroll and exit.** After the spawn above, further ticks with `SPAWN_INTERVAL`=1000.
  - Next tick: x = {636, 676}.
  - After 169 scroll ticks: x_right = 4.
  - Next tick: slot 0 freed, `active`=0, fields zero.
- **Full.** `SPAWN_INTERVAL`=1, 11 ticks.
  - Slots 0–9 active.
  - On the 11th tick `spawn_drop` pulses for one cycle and no slot changes except by scroll.
- **Pause.** Gamemode 10 for 20 ticks mid-game.
  - Outputs and the LFSR sequence are unchanged.
  - Resuming continues exactly as an uninterrupted run minus those ticks.
- **Mode clear.** Gamemode 00 while slots are active: all slots are zero the next cycle, with no tick required.
- **Reset mid-operation.** Assert `rst` with slots active: outputs zero and LFSR = ACE1 on the next cycle.
